// File: rtl/ps2_pkg.sv
// Shared FSM state type and byte constants for the PS/2 receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BREAK  = 8'hF0;

   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR_LO = 8'h00;
   localparam logic [7:0] PS2_ERR_HI = 8'hFF;

   // Device replies that are bytes in their own right but never key events.
   function automatic logic is_reply(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
             (b == PS2_RESEND) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Pin synchronizer, run-length glitch filter and falling-edge strobe for one PS/2 line.
module ps2_line_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_sync,
   output logic o_filt,
   output logic o_fall
);

   localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_filt;
   logic                   r_fall;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_cnt  <= '0;
         r_filt <= 1'b1;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_fall <= 1'b0;
         if (w_sync == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
            // FILTER_LEN-th consecutive differing sample: accept the new level.
            r_filt <= w_sync;
            r_cnt  <= '0;
            r_fall <= r_filt;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_sync = w_sync;
   assign o_filt = r_filt;
   assign o_fall = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding into make/break events.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbdclk,
   input  logic       kbddat,
   output logic [7:0] keycode,
   output logic       byte_valid,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       scan_break,
   output logic       scan_ext,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic w_strobe;
   logic w_dat;
   logic w_clk_sync;
   logic w_clk_filt;
   logic w_dat_filt;
   logic w_dat_fall;
   logic w_unused;
   logic w_to_hit;

   ps2_state_e       r_state;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shreg;
   logic             r_parity;
   logic [TO_W-1:0]  r_tocnt;
   logic             r_ext_pend;
   logic             r_brk_pend;
   logic [7:0]       r_keycode;
   logic             r_byte_valid;
   logic [7:0]       r_scan_code;
   logic             r_scan_valid;
   logic             r_scan_break;
   logic             r_scan_ext;
   logic             r_frame_err;

   ps2_line_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_sync (
      .clk   (clk),
      .rst   (rst),
      .i_pin (kbdclk),
      .o_sync(w_clk_sync),
      .o_filt(w_clk_filt),
      .o_fall(w_strobe)
   );

   ps2_line_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (1)
   ) u_dat_sync (
      .clk   (clk),
      .rst   (rst),
      .i_pin (kbddat),
      .o_sync(w_dat),
      .o_filt(w_dat_filt),
      .o_fall(w_dat_fall)
   );

   assign w_unused = ^{w_clk_sync, w_clk_filt, w_dat_filt, w_dat_fall};

   // Counter is 0 in the cycle after a strobe, so this lands the error pulse
   // exactly TIMEOUT_CYCLES cycles after the last strobe.
   assign w_to_hit = (r_tocnt == TO_W'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_bitcnt     <= '0;
         r_shreg      <= '0;
         r_parity     <= 1'b0;
         r_tocnt      <= '0;
         r_ext_pend   <= 1'b0;
         r_brk_pend   <= 1'b0;
         r_keycode    <= 8'h00;
         r_byte_valid <= 1'b0;
         r_scan_code  <= 8'h00;
         r_scan_valid <= 1'b0;
         r_scan_break <= 1'b0;
         r_scan_ext   <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_scan_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_strobe) begin
            r_tocnt <= '0;
            case (r_state)
               StIdle: begin
                  if (!w_dat) begin
                     r_state  <= StData;
                     r_bitcnt <= '0;
                  end
               end
               StData: begin
                  r_shreg  <= {w_dat, r_shreg[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_state <= StParity;
               end
               StParity: begin
                  r_parity <= w_dat;
                  r_state  <= StStop;
               end
               StStop: begin
                  r_state <= StIdle;
                  if (w_dat && (^{r_shreg, r_parity})) begin
                     r_keycode    <= r_shreg;
                     r_byte_valid <= 1'b1;
                     if (r_shreg == PS2_EXT) begin
                        r_ext_pend <= 1'b1;
                     end else if (r_shreg == PS2_BREAK) begin
                        r_brk_pend <= 1'b1;
                     end else begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                        if (!is_reply(r_shreg)) begin
                           r_scan_valid <= 1'b1;
                           r_scan_code  <= r_shreg;
                           r_scan_break <= r_brk_pend;
                           r_scan_ext   <= r_ext_pend;
                        end
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_ext_pend  <= 1'b0;
                     r_brk_pend  <= 1'b0;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end else if (r_state != StIdle) begin
            if (w_to_hit) begin
               r_state     <= StIdle;
               r_tocnt     <= '0;
               r_frame_err <= 1'b1;
               r_ext_pend  <= 1'b0;
               r_brk_pend  <= 1'b0;
            end else begin
               r_tocnt <= r_tocnt + 1'b1;
            end
         end
      end
   end

   assign keycode    = r_keycode;
   assign byte_valid = r_byte_valid;
   assign scan_code  = r_scan_code;
   assign scan_valid = r_scan_valid;
   assign scan_break = r_scan_break;
   assign scan_ext   = r_scan_ext;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != StIdle);

endmodule
